// File: rtl/uart_pkg.sv
// Shared types and constants for the buffered UART transmitter.
// Latency: none (types, constants and an elaboration-time helper only).
// Backpressure: not applicable.
package uart_pkg;

    // Transmit FSM states. PARITY is only entered when UART_PARITY_EN is defined.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    // Legal parameter ranges, checked at elaboration by the top level.
    localparam int MIN_CLKS_PER_BIT = 2;
    localparam int MIN_DATA_BITS    = 5;
    localparam int MAX_DATA_BITS    = 8;
    localparam int MIN_STOP_BITS    = 1;
    localparam int MAX_STOP_BITS    = 2;
    localparam int MIN_DEPTH        = 2;

    // Clocks occupied by one complete frame: start + data + optional parity + stop.
    function automatic int unsigned frame_clks(input int unsigned clks_per_bit,
                                               input int unsigned data_bits,
                                               input int unsigned stop_bits,
                                               input bit          parity);
        return (1 + data_bits + stop_bits + (parity ? 1 : 0)) * clks_per_bit;
    endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Write/status bus between a character producer and the UART transmitter.
// Latency: wires only.
// Backpressure: none on the strobe; producer watches full, drops raise overflow.
interface uart_tx_fifo_if #(
    parameter int DATA_BITS = 8,
    parameter int DEPTH     = 8
);
    localparam int CW = $clog2(DEPTH + 1);

    logic                 wr_en;
    logic [DATA_BITS-1:0] wr_data;
    logic                 ovf_clr;
    logic                 full;
    logic                 empty;
    logic [CW-1:0]        count;
    logic                 overflow;

    // Producer side: drives the strobe, observes FIFO status.
    modport master (
        output wr_en, wr_data, ovf_clr,
        input  full, empty, count, overflow
    );

    // Transmitter side: consumes the strobe, reports FIFO status.
    modport slave (
        input  wr_en, wr_data, ovf_clr,
        output full, empty, count, overflow
    );

endinterface

// File: rtl/uart_fifo.sv
// Synchronous FIFO with show-ahead read data and occupancy count.
// Latency: write visible at rd_data/empty the edge after it is accepted.
// Backpressure: write accepted when not full or when a read happens on the same edge.
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             push;
    logic             pull;

    // A full FIFO can still take a write when the head leaves on the same edge.
    assign pull    = rd_en && !empty;
    assign push    = wr_en && (!full || pull);
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign rd_data = mem[rd_ptr];

    // Storage array: written only, never reset.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; count separates full from empty.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pull) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pull) begin
                count <= count + CW'(1);
            end else if (!push && pull) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered LSB-first async serial transmitter; optional even parity under UART_PARITY_EN.
// Latency: write into an empty idle FIFO on edge k drives the start bit on edge k+1.
// Backpressure: writes while full with no same-edge pop are dropped and set sticky overflow.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter int DEPTH        = 8
) (
    input  logic            clock,
    input  logic            reset_n,
    uart_tx_fifo_if.slave   host,
    output logic            busy,
    output logic            txd
);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS);

    // Reject illegal configurations at elaboration.
    if (CLKS_PER_BIT < MIN_CLKS_PER_BIT) begin : g_bad_cpb
        $error("uart_tx_fifo: CLKS_PER_BIT must be at least 2");
    end
    if (DATA_BITS < MIN_DATA_BITS || DATA_BITS > MAX_DATA_BITS) begin : g_bad_db
        $error("uart_tx_fifo: DATA_BITS must be 5..8");
    end
    if (STOP_BITS < MIN_STOP_BITS || STOP_BITS > MAX_STOP_BITS) begin : g_bad_sb
        $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
    end
    if (DEPTH < MIN_DEPTH || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_fifo: DEPTH must be a power of two, at least 2");
    end

    tx_state_t            state;
    logic [BW-1:0]        baud_cnt;
    logic [IW-1:0]        bit_idx;
    logic                 stop_idx;
    logic [DATA_BITS-1:0] shift;
    logic [DATA_BITS-1:0] head;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 pop;
    logic                 drop;
    logic                 bit_end;
    logic                 last_stop;
`ifdef UART_PARITY_EN
    logic                 par;
`endif

    assign bit_end   = (baud_cnt == '0);
    assign last_stop = (stop_idx == 1'(STOP_BITS - 1));

    // Head leaves the FIFO when idle, or at the end of the last stop bit for back-to-back frames.
    assign pop  = !fifo_empty &&
                  ((state == IDLE) || (state == STOP && bit_end && last_stop));
    assign drop = host.wr_en && fifo_full && !pop;

    assign host.full  = fifo_full;
    assign host.empty = fifo_empty;

    uart_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .wr_en   (host.wr_en),
        .wr_data (host.wr_data),
        .rd_en   (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (host.count)
    );

    // Sticky overflow; a drop on the same edge as a clear keeps the flag set.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            host.overflow <= 1'b0;
        end else if (drop) begin
            host.overflow <= 1'b1;
        end else if (host.ovf_clr) begin
            host.overflow <= 1'b0;
        end
    end

    // Frame sequencer with baud counter; txd and busy are registered.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            txd      <= 1'b1;
            busy     <= 1'b0;
            baud_cnt <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            shift    <= '0;
`ifdef UART_PARITY_EN
            par      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        state    <= START;
                        shift    <= head;
`ifdef UART_PARITY_EN
                        par      <= ^head;
`endif
                        txd      <= 1'b0;
                        busy     <= 1'b1;
                        baud_cnt <= BW'(CLKS_PER_BIT - 1);
                    end
                end
                START: begin
                    if (bit_end) begin
                        state    <= DATA;
                        bit_idx  <= '0;
                        txd      <= shift[0];
                        baud_cnt <= BW'(CLKS_PER_BIT - 1);
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud_cnt <= BW'(CLKS_PER_BIT - 1);
                        if (bit_idx == IW'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
                            state    <= PARITY;
                            txd      <= par;
`else
                            state    <= STOP;
                            txd      <= 1'b1;
                            stop_idx <= 1'b0;
`endif
                        end else begin
                            shift   <= shift >> 1;
                            bit_idx <= bit_idx + 1'b1;
                            txd     <= shift[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
`ifdef UART_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        state    <= STOP;
                        txd      <= 1'b1;
                        stop_idx <= 1'b0;
                        baud_cnt <= BW'(CLKS_PER_BIT - 1);
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (bit_end) begin
                        baud_cnt <= BW'(CLKS_PER_BIT - 1);
                        if (!last_stop) begin
                            stop_idx <= stop_idx + 1'b1;
                        end else if (pop) begin
                            state <= START;
                            shift <= head;
`ifdef UART_PARITY_EN
                            par   <= ^head;
`endif
                            txd   <= 1'b0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    txd   <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: CLKS_PER_BIT=4, DATA_BITS=8, STOP_BITS=1, DEPTH=4.
// Inputs change 1 time unit after a rising edge; outputs are sampled at that point.
// Parity expectations follow UART_PARITY_EN.
module tb_uart_tx_fifo;
    localparam int CPB   = 4;
    localparam int DB    = 8;
    localparam int SB    = 1;
    localparam int DEPTH = 4;
`ifdef UART_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int FRAME = (1 + DB + PB + SB) * CPB;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    logic busy;
    logic txd;

    int checks = 0;
    int passed = 0;

    uart_tx_fifo_if #(.DATA_BITS(DB), .DEPTH(DEPTH)) bus ();

    uart_tx_fifo #(
        .CLKS_PER_BIT (CPB),
        .DATA_BITS    (DB),
        .STOP_BITS    (SB),
        .DEPTH        (DEPTH)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .host    (bus.slave),
        .busy    (busy),
        .txd     (txd)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Checks txd/busy every clock of one frame, starting 'skip' clocks after the start-bit edge.
    task automatic check_frame(input logic [7:0] d, input int skip, input string tag);
        logic [11:0] bits;
        bits = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < DB; i++) bits[1 + i] = d[i];
`ifdef UART_PARITY_EN
        bits[1 + DB] = ^d;
`endif
        for (int i = skip; i < FRAME; i++) begin
            check($sformatf("%s txd clk%0d", tag, i), 32'(txd), 32'(bits[i / CPB]));
            check($sformatf("%s busy clk%0d", tag, i), 32'(busy), 32'd1);
            tick();
        end
    endtask

    initial begin
        logic [2:0] exp_cnt [6];
        exp_cnt = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
        bus.wr_en   = 1'b0;
        bus.wr_data = '0;
        bus.ovf_clr = 1'b0;

        // Reset state
        repeat (3) tick();
        check("rst txd", 32'(txd), 32'd1);
        check("rst busy", 32'(busy), 32'd0);
        check("rst full", 32'(bus.full), 32'd0);
        check("rst empty", 32'(bus.empty), 32'd1);
        check("rst count", 32'(bus.count), 32'd0);
        check("rst overflow", 32'(bus.overflow), 32'd0);
        reset_n = 1'b1;

        // 1: idle for 100 clocks
        for (int i = 0; i < 100; i++) begin
            check("idle txd", 32'(txd), 32'd1);
            check("idle empty", 32'(bus.empty), 32'd1);
            check("idle count", 32'(bus.count), 32'd0);
            check("idle busy", 32'(busy), 32'd0);
            tick();
        end

        // 2: single byte 0x55
        bus.wr_en = 1'b1; bus.wr_data = 8'h55;
        tick();
        bus.wr_en = 1'b0;
        check("t2 k txd", 32'(txd), 32'd1);
        check("t2 k count", 32'(bus.count), 32'd1);
        check("t2 k busy", 32'(busy), 32'd0);
        tick();
        check("t2 k+1 count", 32'(bus.count), 32'd0);
        check_frame(8'h55, 0, "t2");
        check("t2 end busy", 32'(busy), 32'd0);
        check("t2 end txd", 32'(txd), 32'd1);
        check("t2 end empty", 32'(bus.empty), 32'd1);

        // 3: back-to-back 0xA3, 0x0F
        bus.wr_en = 1'b1; bus.wr_data = 8'hA3;
        tick();
        bus.wr_data = 8'h0F;
        tick();
        bus.wr_en = 1'b0;
        check("t3 count", 32'(bus.count), 32'd1);
        check_frame(8'hA3, 0, "t3a");
        check("t3 mid count", 32'(bus.count), 32'd0);
        check_frame(8'h0F, 0, "t3b");
        check("t3 end busy", 32'(busy), 32'd0);

        // 4: six writes into depth 4, sixth dropped
        for (int i = 0; i < 6; i++) begin
            bus.wr_en = 1'b1; bus.wr_data = 8'(8'h11 * (i + 1));
            tick();
            check($sformatf("t4 count w%0d", i), 32'(bus.count), 32'(exp_cnt[i]));
            check($sformatf("t4 ovf w%0d", i), 32'(bus.overflow), (i == 5) ? 32'd1 : 32'd0);
        end
        bus.wr_en = 1'b0;
        check("t4 full", 32'(bus.full), 32'd1);
        bus.ovf_clr = 1'b1;
        tick();
        bus.ovf_clr = 1'b0;
        check("t4 ovf cleared", 32'(bus.overflow), 32'd0);
        check_frame(8'h11, 5, "t4f0");
        check_frame(8'h22, 0, "t4f1");
        check_frame(8'h33, 0, "t4f2");
        check_frame(8'h44, 0, "t4f3");
        check_frame(8'h55, 0, "t4f4");
        for (int i = 0; i < FRAME; i++) begin
            check("t4 no 6th txd", 32'(txd), 32'd1);
            check("t4 no 6th busy", 32'(busy), 32'd0);
            tick();
        end

        // Drop coinciding with ovf_clr keeps overflow set
        for (int i = 0; i < 5; i++) begin
            bus.wr_en = 1'b1; bus.wr_data = 8'(8'hA0 + i);
            tick();
            check($sformatf("t6 count w%0d", i), 32'(bus.count), 32'(exp_cnt[i]));
        end
        bus.wr_data = 8'hEE; bus.ovf_clr = 1'b1;
        tick();
        bus.wr_en = 1'b0;
        check("ovf clr+drop", 32'(bus.overflow), 32'd1);
        check("ovf clr+drop count", 32'(bus.count), 32'd4);
        tick();
        bus.ovf_clr = 1'b0;
        check("ovf clr alone", 32'(bus.overflow), 32'd0);

        // 6: reset during data bit 3 of 0xA0 (bit 3 = 0); now 5 clocks into the frame
        repeat (12) tick();
        check("t6 pre-reset txd", 32'(txd), 32'd0);
        check("t6 pre-reset busy", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        check("t6 async txd", 32'(txd), 32'd1);
        check("t6 async count", 32'(bus.count), 32'd0);
        check("t6 async empty", 32'(bus.empty), 32'd1);
        check("t6 async busy", 32'(busy), 32'd0);
        repeat (2) tick();
        reset_n = 1'b1;
        for (int i = 0; i < 2 * FRAME; i++) begin
            check("t6 no residual txd", 32'(txd), 32'd1);
            check("t6 no residual busy", 32'(busy), 32'd0);
            tick();
        end
        bus.wr_en = 1'b1; bus.wr_data = 8'h5A;
        tick();
        bus.wr_en = 1'b0;
        tick();
        check_frame(8'h5A, 0, "t6 new");
        check("t6 end busy", 32'(busy), 32'd0);

`ifdef UART_PARITY_EN
        // 5: parity frames, 0x07 (odd ones -> parity 1) and 0x03 (parity 0)
        bus.wr_en = 1'b1; bus.wr_data = 8'h07;
        tick();
        bus.wr_en = 1'b0;
        tick();
        check_frame(8'h07, 0, "t5 07");
        check("t5 07 idle", 32'(busy), 32'd0);
        bus.wr_en = 1'b1; bus.wr_data = 8'h03;
        tick();
        bus.wr_en = 1'b0;
        tick();
        check_frame(8'h03, 0, "t5 03");
        check("t5 03 idle", 32'(busy), 32'd0);
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
